// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type, SPI mode and default sizing for the SPI byte master
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int SPI_DATA_W_DEF  = 8;
    localparam int SPI_CLK_DIV_DEF = 4;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period divider emitting alternating one-cycle rise/fall strobes
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Held at RELOAD while disabled so the first half-period is a full CLK_DIV cycles.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = RELOAD;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = RELOAD;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign rise_stb_o = en_i && (cnt_q == '0) && !phase_q;
    assign fall_stb_o = en_i && (cnt_q == '0) &&  phase_q;

endmodule

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - single-byte mode-0 SPI master with registered outputs
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int DATA_W  = SPI_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bits_q, bits_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;

    logic rise_stb, fall_stb, sample_stb, launch_stb;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == ST_XFER),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    assign sample_stb = SAMPLE_ON_RISE ? rise_stb : fall_stb;
    assign launch_stb = SAMPLE_ON_RISE ? fall_stb : rise_stb;

    // Sampled miso enters the LSB as the register shifts, so the MSB always holds the next bit out.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                if (tx_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = RELOAD;
                    bits_d  = '0;
                    shift_d = tx_data;
                    mosi_d  = tx_data[DATA_W-1];
                    cs_n_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_XFER: begin
                if (rise_stb || fall_stb) begin
                    sclk_d = ~sclk_q;
                end
                if (sample_stb) begin
                    shift_d = {shift_q[DATA_W-2:0], miso};
                end
                if (launch_stb) begin
                    if (bits_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                        cnt_d   = RELOAD;
                    end else begin
                        mosi_d = shift_q[DATA_W-1];
                        bits_d = bits_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bits_q     <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= SPI_CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - scoreboard bench for spi_byte_master at CLK_DIV=4 and CLK_DIV=1
module tb_spi_byte_master;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, rx_valid, busy, sclk, mosi, miso, cs_n;
    logic [7:0] rx_data;

    logic [7:0] tx_data1 = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1, rx_valid1, busy1, sclk1, mosi1, cs_n1;
    logic [7:0] rx_data1;

    bit         loopback = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [3:0] s_cnt = 4'd0;

    int  checks = 0;
    int  errors = 0;
    exp_t exp_q[$];
    time  acc_q[$];
    logic [7:0] exp1_q[$];
    logic [7:0] mosi_bits = 8'h00;
    int  rise_cnt = 0, rx_cnt = 0, rx1_cnt = 0;
    int  sclk_viol = 0, cs_glitch = 0;
    bit  in_xfer = 1'b0, prev_rv = 1'b0;
    time last_rx_t = 0, rx_gap = 0, acc1_t = 0, last1 = 0, period1 = 0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : ((s_cnt < 4'd8) ? slave_byte[3'd7 - s_cnt[2:0]] : 1'b0);

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) s_cnt <= 4'd0;
        else      s_cnt <= s_cnt + 4'd1;
    end

    spi_byte_master #(.CLK_DIV(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    spi_byte_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1), .mosi(mosi1),
        .miso(mosi1), .cs_n(cs_n1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge sclk) begin
        mosi_bits = {mosi_bits[6:0], mosi};
        rise_cnt++;
    end

    always @(posedge sclk1) begin
        if (last1 != 0) period1 = $time - last1;
        last1 = $time;
    end

    // Monitor for the CLK_DIV=4 instance
    always @(negedge clk) begin
        exp_t e;
        time  a;
        if (!rst_n) begin
            in_xfer = 1'b0;
            prev_rv = 1'b0;
            acc_q.delete();
        end else begin
            if (cs_n && sclk) sclk_viol++;
            if (in_xfer && cs_n && !rx_valid) cs_glitch++;
            if (rx_valid) begin
                rx_cnt++;
                chk("rx_valid_one_cycle", 32'(prev_rv), 32'd0);
                chk("cs_n_high_at_rx_valid", 32'(cs_n), 32'd1);
                chk("tx_ready_at_rx_valid", 32'(tx_ready), 32'd1);
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_valid: got rx_data %0h expected no pulse", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.rx));
                    chk("latency", 32'(($time - 5 - a) / 10), 32'd72);
                    chk("sclk_rises", 32'(rise_cnt), 32'd8);
                    chk("mosi_bits", 32'(mosi_bits), 32'(e.tx));
                end
                if (last_rx_t != 0) rx_gap = ($time - last_rx_t) / 10;
                last_rx_t = $time;
                in_xfer = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                acc_q.push_back($time + 5);
                rise_cnt = 0;
                in_xfer = 1'b1;
            end
            prev_rv = rx_valid;
        end
    end

    // Monitor for the CLK_DIV=1 instance
    always @(negedge clk) begin
        logic [7:0] e1;
        if (rst_n) begin
            if (rx_valid1) begin
                rx1_cnt++;
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL div1_unexpected_rx_valid: got rx_data %0h expected no pulse", rx_data1);
                end else begin
                    e1 = exp1_q.pop_front();
                    chk("div1_rx_data", 32'(rx_data1), 32'(e1));
                    chk("div1_latency", 32'(($time - 5 - acc1_t) / 10), 32'd18);
                    chk("div1_sclk_period", 32'(period1 / 10), 32'd2);
                end
            end
            if (tx_valid1 && tx_ready1) acc1_t = $time + 5;
        end
    end

    task automatic send(input logic [7:0] tx, input logic [7:0] rx, input bit keep, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        tx_data  = tx;
        tx_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                if (push) begin
                    e.rx = rx;
                    e.tx = tx;
                    exp_q.push_back(e);
                end
                @(posedge clk);
                #1;
                if (!keep) tx_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no tx_ready expected acceptance of %0h", tx);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_cnt >= n) return;
        end
        checks++;
        errors++;
        $display("FAIL rx_timeout: got %0d pulses expected %0d", rx_cnt, n);
    endtask

    initial begin
        int rises_before;
        bit seen;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cs_n", 32'(cs_n), 32'd1);
        chk("reset_sclk", 32'(sclk), 32'd0);
        chk("reset_mosi", 32'(mosi), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tx_ready", 32'(tx_ready), 32'd1);
        chk("reset_tx_ready_div1", 32'(tx_ready1), 32'd1);

        loopback = 1'b1;
        send(8'hA5, 8'hA5, 1'b0, 1'b1);
        wait_rx(1);

        loopback   = 1'b0;
        slave_byte = 8'h3C;
        send(8'hFF, 8'h3C, 1'b0, 1'b1);
        wait_rx(2);
        chk("cs_n_low_throughout", 32'(cs_glitch), 32'd0);

        loopback = 1'b1;
        send(8'h01, 8'h01, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b0, 1'b1);
        wait_rx(4);
        chk("b2b_rx_gap", 32'(rx_gap), 32'd73);

        send(8'h33, 8'h33, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_rx(5);
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("busy_ignored_rx_count", 32'(rx_cnt), 32'd5);
        chk("busy_ignored_no_accept", 32'(acc_q.size()), 32'd0);
        chk("rx_data_holds", 32'(rx_data), 32'h33);
        chk("idle_cs_n", 32'(cs_n), 32'd1);

        send(8'hE7, 8'hE7, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (rise_cnt >= 3) seen = 1'b1;
        end
        chk("abort_reached_bit3", 32'(seen), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rx_valid", 32'(rx_valid), 32'd0);
        chk("abort_rx_data_cleared", 32'(rx_data), 32'd0);
        chk("abort_tx_ready", 32'(tx_ready), 32'd1);
        rises_before = rise_cnt;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("abort_no_sclk_edges", 32'(rise_cnt), 32'(rises_before));
        chk("abort_no_rx_valid", 32'(rx_cnt), 32'd5);
        send(8'hC3, 8'hC3, 1'b0, 1'b1);
        wait_rx(6);

        @(posedge clk);
        #1;
        tx_data1  = 8'h96;
        tx_valid1 = 1'b1;
        exp1_q.push_back(8'h96);
        @(posedge clk);
        #1 tx_valid1 = 1'b0;
        for (int i = 0; i < 100 && rx1_cnt == 0; i++) @(negedge clk);
        chk("div1_rx_count", 32'(rx1_cnt), 32'd1);

        chk("sclk_low_when_cs_high", 32'(sclk_viol), 32'd0);
        chk("cs_n_no_glitch", 32'(cs_glitch), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter DATA_W, default 8, bits per transfer.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 tx_data  in  DATA_W  byte to transmit, MSB first.
REQ-006 tx_valid  in  1  tx_data is valid.
REQ-007 tx_ready  out  1  block can accept a transfer.
REQ-008 rx_data  out  DATA_W  last byte received.
REQ-009 rx_valid  out  1  one-cycle pulse: rx_data updated.
REQ-010 busy  out  1  transfer in progress (any state other than IDLE).
REQ-011 sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 mosi  out  1  SPI serial data out.
REQ-013 miso  in  1  SPI serial data in.
REQ-014 cs_n  out  1  active-low chip select.

Function
REQ-015 States: IDLE, SETUP, XFER, HOLD; all outputs registered except tx_ready.
REQ-016 tx_ready = 1 only in IDLE; a transfer is accepted on a rising edge with tx_valid=1 and tx_ready=1.
REQ-017 tx_valid asserted while busy=1 is ignored; tx_data is sampled only at acceptance.
REQ-018 On acceptance: latch tx_data into the shift register; next state SETUP; cs_n=0, busy=1, mosi=tx_data[DATA_W-1] from the next cycle.
REQ-019 SETUP: hold sclk=0 for CLK_DIV cycles, then go to XFER.
REQ-020 XFER: toggle sclk every CLK_DIV cycles, giving 2*DATA_W half-periods.
REQ-021 XFER rising sclk edge: sample miso into the shift-register LSB.
REQ-022 XFER falling sclk edge: shift left and drive the next MSB on mosi; no shift after the last falling edge.
REQ-023 After the final falling edge, go to HOLD: sclk=0, cs_n=0 for CLK_DIV cycles.
REQ-024 End of HOLD: rx_data <= shift register; rx_valid=1 for exactly one cycle; cs_n=1, busy=0; go to IDLE.
REQ-025 Latency: rx_valid rises exactly (2*DATA_W+2)*CLK_DIV cycles after the accepting edge (72 for defaults).
REQ-026 cs_n stays high for at least one cycle between back-to-back transfers; tx_ready=1 in the cycle rx_valid=1.
REQ-027 rx_data holds its value until the next rx_valid.
REQ-028 CLK_DIV=1: sclk = clk/2; all rules above still hold.
REQ-029 The divider counter is $clog2(CLK_DIV+1) bits wide, reloads at each sclk edge, and never wraps mid half-period.

Reset
REQ-030 rst_n=0 at a rising edge forces IDLE, cs_n=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, busy=0 and clears counters and shift register.
REQ-031 Reset mid-transfer aborts immediately: no rx_valid, no further sclk edges.
REQ-032 tx_ready=1 from the first cycle after rst_n returns high.

Structure
REQ-033 Shared package spi_pkg holds the state enumeration, mode constants (CPOL/CPHA), and the default DATA_W and CLK_DIV.
REQ-034 One sub-module, spi_clk_gen: CLK_DIV counter emitting one-cycle rise_stb/fall_stb strobes, enabled only in XFER.

Verification
REQ-035 Loopback (miso tied to mosi), CLK_DIV=4, tx_data=8'hA5 -> rx_data=8'hA5, rx_valid pulse 72 cycles after accept, exactly 8 sclk rising edges, mosi bits 1,0,1,0,0,1,0,1.
REQ-036 Slave model returns 8'h3C, tx_data=8'hFF -> rx_data=8'h3C; cs_n low throughout; sclk=0 whenever cs_n=1.
REQ-037 Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> two transfers, cs_n high >=1 cycle between them, rx_valid pulses 73 cycles apart.
REQ-038 tx_valid pulsed with 8'h55 while busy -> not accepted; only the first byte appears on mosi.
REQ-039 rst_n=0 during bit 3 -> next cycle cs_n=1, sclk=0, no rx_valid; a following transfer of 8'hC3 completes correctly.
REQ-040 CLK_DIV=1, loopback 8'h96 -> rx_data=8'h96 after 18 cycles; sclk period 2 cycles.
